// File: rtl/systolic_pkg.sv
// Shared constants, FSM encoding and counter types for the systolic array feeder.
package systolic_pkg;

    localparam int unsigned PE_ROW           = 16;
    localparam int unsigned PE_COL           = 16;
    localparam int unsigned INPUT_DATA_WIDTH = 8;
    localparam int unsigned ROW_CNT_W        = 5;
    localparam int unsigned VEC_CNT_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    typedef logic [ROW_CNT_W-1:0] row_cnt_t;
    typedef logic [VEC_CNT_W-1:0] vec_cnt_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// Job control, weight/activation handshakes and array-facing buses of the feeder.
interface systolic_feeder_if #(
    parameter int unsigned PE_ROW           = systolic_pkg::PE_ROW,
    parameter int unsigned PE_COL           = systolic_pkg::PE_COL,
    parameter int unsigned INPUT_DATA_WIDTH = systolic_pkg::INPUT_DATA_WIDTH
);
    import systolic_pkg::*;

    logic                               start;
    vec_cnt_t                           num_vec;
    logic                               w_valid;
    logic                               w_ready;
    logic [INPUT_DATA_WIDTH*PE_COL-1:0] w_data;
    logic                               a_valid;
    logic                               a_ready;
    logic [INPUT_DATA_WIDTH*PE_ROW-1:0] a_data;
    logic [INPUT_DATA_WIDTH*PE_ROW-1:0] in_a_bus;
    logic [INPUT_DATA_WIDTH*PE_COL-1:0] in_b_bus;
    logic [PE_ROW-1:0]                  enable;
    logic                               save;
    logic                               busy;
    logic                               done;

    modport slave (
        input  start, num_vec, w_valid, w_data, a_valid, a_data,
        output w_ready, a_ready, in_a_bus, in_b_bus, enable, save, busy, done
    );

    modport master (
        output start, num_vec, w_valid, w_data, a_valid, a_data,
        input  w_ready, a_ready, in_a_bus, in_b_bus, enable, save, busy, done
    );

endinterface

// File: rtl/systolic_skew_line.sv
// DEPTH-stage {valid, data} delay line; one per array row to build the diagonal skew.
module systolic_skew_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    localparam int unsigned DATA_W = DEPTH * WIDTH;

    logic [DEPTH-1:0]  v_q;
    logic [DATA_W-1:0] d_q;

    // New slot enters at the bottom; the oldest slot falls off the top after being presented.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q <= '0;
            d_q <= '0;
        end else begin
            v_q <= DEPTH'({v_q, in_valid});
            d_q <= DATA_W'({d_q, in_data});
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DATA_W-1 -: WIDTH];

endmodule

// File: rtl/systolic_feeder.sv
// Sequences weight load, skewed activation streaming and drain into a PE_ROW x PE_COL array.
module systolic_feeder #(
    parameter int unsigned PE_ROW           = systolic_pkg::PE_ROW,
    parameter int unsigned PE_COL           = systolic_pkg::PE_COL,
    parameter int unsigned INPUT_DATA_WIDTH = systolic_pkg::INPUT_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rstn,
    systolic_feeder_if.slave  bus
);
    import systolic_pkg::*;

    localparam int unsigned DW = INPUT_DATA_WIDTH;

    state_t   state_q, state_d;
    row_cnt_t row_cnt_q;
    vec_cnt_t vec_cnt_q, k_q;

    logic hs_w, hs_a, last_row, last_vec, last_drain;
    logic                 save_q;
    logic [PE_COL*DW-1:0] b_q;
    logic [PE_ROW*DW-1:0] a_gated;
    logic [PE_ROW*DW-1:0] a_bus;
    logic [PE_ROW-1:0]    en;

    assign hs_w       = bus.w_valid && (state_q == ST_LOAD);
    assign hs_a       = bus.a_valid && (state_q == ST_STREAM);
    assign last_row   = (row_cnt_q == ROW_CNT_W'(PE_ROW - 1));
    assign last_vec   = (VEC_CNT_W'(vec_cnt_q + VEC_CNT_W'(1)) == k_q);
    assign last_drain = (row_cnt_q == ROW_CNT_W'(PE_ROW - 2));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.start) state_d = ST_LOAD;
            ST_LOAD:   if (hs_w && last_row) state_d = (k_q == '0) ? ST_DRAIN : ST_STREAM;
            ST_STREAM: if (hs_a && last_vec) state_d = ST_DRAIN;
            ST_DRAIN:  if (last_drain) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Handshake readiness and status are pure functions of the current state.
    always_comb begin
        bus.w_ready = 1'b0;
        bus.a_ready = 1'b0;
        bus.busy    = (state_q != ST_IDLE);
        bus.done    = 1'b0;
        case (state_q)
            ST_LOAD:   bus.w_ready = 1'b1;
            ST_STREAM: bus.a_ready = 1'b1;
            ST_DRAIN:  bus.done    = last_drain;
            default:   ;
        endcase
    end

    // Row counter doubles as the drain cycle counter; it restarts on every state change.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_q       <= '0;
            row_cnt_q <= '0;
            vec_cnt_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && bus.start) k_q <= bus.num_vec;
            if (state_d != state_q)
                row_cnt_q <= '0;
            else if (hs_w || (state_q == ST_DRAIN))
                row_cnt_q <= ROW_CNT_W'(row_cnt_q + ROW_CNT_W'(1));
            if (state_q != ST_STREAM)
                vec_cnt_q <= '0;
            else if (hs_a)
                vec_cnt_q <= VEC_CNT_W'(vec_cnt_q + VEC_CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            save_q <= 1'b0;
            b_q    <= '0;
        end else begin
            save_q <= hs_w;
            b_q    <= hs_w ? bus.w_data : '0;
        end
    end

    // Bubbles enter the lines as zero-data invalid slots to keep the diagonal aligned.
    assign a_gated = hs_a ? bus.a_data : '0;

    for (genvar i = 0; i < PE_ROW; i++) begin : g_row
        systolic_skew_line #(
            .DEPTH (i + 1),
            .WIDTH (DW)
        ) u_line (
            .clk       (clk),
            .rstn      (rstn),
            .in_valid  (hs_a),
            .in_data   (a_gated[i*DW +: DW]),
            .out_valid (en[i]),
            .out_data  (a_bus[i*DW +: DW])
        );
    end

    assign bus.save     = save_q;
    assign bus.in_b_bus = b_q;
    assign bus.enable   = en;
    assign bus.in_a_bus = a_bus;

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized and directed checks of systolic_feeder against a job-level reference model.
module tb_systolic_feeder;

    localparam int unsigned R  = 4;
    localparam int unsigned C  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned RQ = 16;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    systolic_feeder_if #(.PE_ROW(R), .PE_COL(C), .INPUT_DATA_WIDTH(DW)) bus ();

    systolic_feeder #(.PE_ROW(R), .PE_COL(C), .INPUT_DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Model: job phase (0 idle, 1 load, 2 stream, 3 drain), remaining work, and a
    // cycle-indexed ring of expected array-side outputs.
    int m_mode, m_rows, m_vecs, m_drain, m_k;
    logic [R-1:0]    rq_en   [RQ];
    logic [R*DW-1:0] rq_a    [RQ];
    logic            rq_save [RQ];
    logic [C*DW-1:0] rq_b    [RQ];
    int cyc, checks, errors, done_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < int'(RQ); s++) begin
            rq_en[s] = '0; rq_a[s] = '0; rq_save[s] = 1'b0; rq_b[s] = '0;
        end
        m_mode = 0; m_rows = 0; m_vecs = 0; m_drain = 0; m_k = 0;
    endtask

    task automatic check_outputs();
        int s;
        s = cyc % int'(RQ);
        check("in_a_bus", 64'(bus.in_a_bus), 64'(rq_a[s]));
        check("enable",   64'(bus.enable),   64'(rq_en[s]));
        check("save",     64'(bus.save),     64'(rq_save[s]));
        check("in_b_bus", 64'(bus.in_b_bus), 64'(rq_b[s]));
        check("w_ready",  64'(bus.w_ready),  64'(m_mode == 1));
        check("a_ready",  64'(bus.a_ready),  64'(m_mode == 2));
        check("busy",     64'(bus.busy),     64'(m_mode != 0));
        check("done",     64'(bus.done),     64'((m_mode == 3) && (m_drain == 1)));
        if (bus.done) done_seen++;
        rq_en[s] = '0; rq_a[s] = '0; rq_save[s] = 1'b0; rq_b[s] = '0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic cycle(input logic sv, input logic [15:0] nv, input logic wv,
                         input logic [C*DW-1:0] wd, input logic av, input logic [R*DW-1:0] ad);
        int nx, sl;
        bus.start = sv; bus.num_vec = nv;
        bus.w_valid = wv; bus.w_data = wd;
        bus.a_valid = av; bus.a_data = ad;
        nx = (cyc + 1) % int'(RQ);
        case (m_mode)
            0: if (sv) begin m_k = int'(nv); m_rows = R; m_mode = 1; end
            1: if (wv) begin
                rq_save[nx] = 1'b1; rq_b[nx] = wd; m_rows--;
                if (m_rows == 0) begin
                    if (m_k == 0) begin m_mode = 3; m_drain = R - 1; end
                    else begin m_mode = 2; m_vecs = m_k; end
                end
            end
            2: if (av) begin
                for (int i = 0; i < int'(R); i++) begin
                    sl = (cyc + 1 + i) % int'(RQ);
                    rq_en[sl][i] = 1'b1;
                    rq_a[sl][i*DW +: DW] = ad[i*DW +: DW];
                end
                m_vecs--;
                if (m_vecs == 0) begin m_mode = 3; m_drain = R - 1; end
            end
            3: begin m_drain--; if (m_drain == 0) m_mode = 0; end
            default: m_mode = 0;
        endcase
        @(posedge clk); #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 16'd0, 1'b0, '0, 1'b0, '0);
    endtask

    function automatic logic [C*DW-1:0] wrow(input logic [7:0] b);
        return {C{b}};
    endfunction

    function automatic logic [R*DW-1:0] vec(input logic [7:0] base);
        logic [R*DW-1:0] v;
        for (int i = 0; i < int'(R); i++) v[i*DW +: DW] = 8'(base + 8'(i));
        return v;
    endfunction

    task automatic load_rows();
        for (int r = 1; r <= int'(R); r++) cycle(1'b0, 16'd0, 1'b1, wrow(8'(r)), 1'b0, '0);
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        bus.start = 1'b0; bus.w_valid = 1'b0; bus.a_valid = 1'b0;
        #1;
        check("rst_in_a_bus", 64'(bus.in_a_bus), 64'd0);
        check("rst_enable",   64'(bus.enable),   64'd0);
        check("rst_save",     64'(bus.save),     64'd0);
        check("rst_in_b_bus", 64'(bus.in_b_bus), 64'd0);
        check("rst_ready",    64'({bus.w_ready, bus.a_ready}), 64'd0);
        check("rst_busy_done", 64'({bus.busy, bus.done}), 64'd0);
        model_clear();
        @(posedge clk); #3 rstn = 1'b1;
        @(posedge clk); #1;
        cyc++;
        check_outputs();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; done_seen = 0;
        rstn = 1'b0;
        bus.start = 1'b0; bus.num_vec = '0; bus.w_valid = 1'b0; bus.w_data = '0;
        bus.a_valid = 1'b0; bus.a_data = '0;
        model_clear();
        #2 check_outputs();
        @(posedge clk); #3 rstn = 1'b1;

        // Weight load then two back-to-back vectors.
        done_seen = 0;
        cycle(1'b1, 16'd2, 1'b0, '0, 1'b0, '0);
        load_rows();
        cycle(1'b0, 16'd0, 1'b0, '0, 1'b1, vec(8'h10));
        cycle(1'b0, 16'd0, 1'b0, '0, 1'b1, vec(8'h20));
        idle(8);
        check("skew_done_cnt", 64'(done_seen), 64'd1);

        // Bubble between two vectors.
        done_seen = 0;
        cycle(1'b1, 16'd2, 1'b0, '0, 1'b0, '0);
        load_rows();
        cycle(1'b0, 16'd0, 1'b0, '0, 1'b1, {R{8'h11}});
        cycle(1'b0, 16'd0, 1'b0, '0, 1'b0, {R{8'h55}});
        cycle(1'b0, 16'd0, 1'b0, '0, 1'b1, {R{8'h33}});
        idle(8);
        check("bubble_done_cnt", 64'(done_seen), 64'd1);

        // K=0: straight from load to drain.
        done_seen = 0;
        cycle(1'b1, 16'd0, 1'b0, '0, 1'b0, '0);
        load_rows();
        idle(8);
        check("k0_done_cnt", 64'(done_seen), 64'd1);

        // Reset after 1 of 3 vectors, then a fresh job.
        done_seen = 0;
        cycle(1'b1, 16'd3, 1'b0, '0, 1'b0, '0);
        load_rows();
        cycle(1'b0, 16'd0, 1'b0, '0, 1'b1, vec(8'h40));
        do_reset();
        idle(4);
        check("abort_done_cnt", 64'(done_seen), 64'd0);
        cycle(1'b1, 16'd2, 1'b0, '0, 1'b0, '0);
        load_rows();
        cycle(1'b0, 16'd0, 1'b0, '0, 1'b1, vec(8'h50));
        cycle(1'b0, 16'd0, 1'b0, '0, 1'b1, vec(8'h60));
        idle(8);
        check("post_reset_done_cnt", 64'(done_seen), 64'd1);

        // Start pulses while busy must not resample K.
        done_seen = 0;
        cycle(1'b1, 16'd3, 1'b0, '0, 1'b0, '0);
        cycle(1'b1, 16'd1, 1'b1, wrow(8'hA1), 1'b0, '0);
        cycle(1'b1, 16'd7, 1'b1, wrow(8'hA2), 1'b0, '0);
        cycle(1'b0, 16'd0, 1'b1, wrow(8'hA3), 1'b0, '0);
        cycle(1'b0, 16'd0, 1'b1, wrow(8'hA4), 1'b0, '0);
        for (int v = 0; v < 3; v++) cycle(1'b1, 16'd1, 1'b0, '0, 1'b1, vec(8'(8'h70 + 8'(v * 16))));
        cycle(1'b0, 16'd0, 1'b0, '0, 1'b0, '0);
        cycle(1'b1, 16'd9, 1'b0, '0, 1'b0, '0);
        cycle(1'b0, 16'd0, 1'b0, '0, 1'b0, '0);
        check("busy_start_done_cnt", 64'(done_seen), 64'd1);
        idle(6);

        // Randomized jobs with gappy handshakes and stray start pulses.
        for (int j = 0; j < 20; j++) begin
            done_seen = 0;
            cycle(1'b1, 16'($urandom_range(0, 6)), 1'b0, '0, 1'b0, '0);
            for (int n = 0; n < 300 && m_mode != 0; n++)
                cycle(($urandom % 8) == 0, 16'($urandom_range(0, 9)),
                      1'($urandom % 2), 32'($urandom),
                      ($urandom % 3) != 0, 32'($urandom));
            check("rand_done_cnt", 64'(done_seen), 64'd1);
            idle(int'($urandom_range(1, 5)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
